iic_eeprom_wr_block: RTL
========================

# iic_eeprom_wr_block

Parametrised EEPROM block writer that sits between a data-producing client and the I2C master command port. It writes `len` bytes from a ready/valid byte stream into a 24-series EEPROM starting at `start_addr`. The transfer is split automatically into page-aligned COMPLETE_WR bursts, and the block waits the EEPROM internal write cycle between bursts. It generalises the fixed single-burst counting-pattern writer to configurable device address, address width, page size, length and stream-fed data.

## Interface
Parameters:
- `DEV_ADDR`, 7'b1010_000: I2C device address (7 bits).
- `ADDR_BYTES`, 2: EEPROM memory address bytes, legal values 1 or 2.
- `PAGE_BYTES`, 16: EEPROM page size in bytes, power of 2, 2..256.
- `MEM_AW`, 16: width of `start_addr`.
- `LEN_W`, 16: width of `len`.
- `TWR_CYCLES`, 500000: clock cycles to wait after each burst's `finish`.

Ports:
- `clock`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle request, sampled only in IDLE.
- `start_addr`, in, MEM_AW: first EEPROM byte address.
- `len`, in, LEN_W: number of bytes to write.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse when the transfer is complete.
- `src_data`, in, 8: payload byte.
- `src_vld`, in, 1: payload valid.
- `src_ready`, out, 1: payload accepted on `src_vld & src_ready`.
- `cmd`, out, 4: I2C master command, constant 4'd1 (COMPLETE_WR).
- `cmd_vld`, out, 1: command request.
- `cmd_ready`, in, 1: command accepted on `cmd_vld & cmd_ready`.
- `addr`, out, 7: I2C slave address for the current burst.
- `burst_len`, out, 24: bytes in the current burst, including memory-address bytes.
- `wr_data`, out, 8: byte to the master.
- `wr_vld`, out, 1: byte valid.
- `wr_ready`, in, 1: byte accepted on `wr_vld & wr_ready`.
- `wr_last`, out, 1: marks the final byte of the burst.
- `rd_ready`, out, 1: constant 1.
- `finish`, in, 1: one-cycle pulse from the master after STOP.

## Operation
- State machine states: IDLE, CMD, ADDR, DATA, WAIT_FSH, TWR, DONE.
- IDLE:
  - `start` latches `cur_addr = start_addr` and `remain = len`.
  - If `len == 0`, go to DONE; otherwise go to CMD.
  - `start` in any other state is ignored.
- Chunk size on entry to CMD: `n = min(remain, PAGE_BYTES - cur_addr[log2(PAGE_BYTES)-1:0])`.
  - `burst_len = ADDR_BYTES + n`, zero-extended to 24 bits.
  - `n` and `burst_len` stay registered for the whole burst.
- I2C address:
  - ADDR_BYTES=2: `addr = DEV_ADDR`.
  - ADDR_BYTES=1: `addr = DEV_ADDR | {4'b0, cur_addr[10:8]}` (block-select bits).
- CMD: `cmd_vld` is high until `cmd_ready`, then go to ADDR.
- ADDR:
  - Send the memory address bytes MSB first: `cur_addr[15:8]` (ADDR_BYTES=2 only), then `cur_addr[7:0]`.
  - `wr_vld` is high and `wr_data` is held stable until each handshake.
  - After the last address byte is accepted, go to DATA.
- DATA:
  - Combinational pass-through: `wr_data = src_data`, `wr_vld = src_vld`, `src_ready = wr_ready`.
  - A byte counter increments on each accepted byte.
  - `wr_last = 1` while the counter equals `n-1`.
  - On the n-th accepted byte go to WAIT_FSH; `cur_addr += n`, `remain -= n`.
  - `src_ready = 0` in every state other than DATA.
- WAIT_FSH: wait for `finish`, then go to TWR.
- TWR:
  - Count `TWR_CYCLES` cycles.
  - Then go to CMD if `remain != 0`, else DONE.
- DONE: `done = 1` for one cycle, then IDLE.
- `cur_addr` wraps modulo 2^MEM_AW; no error is flagged.
- Ignored inputs: `cmd_ready` outside CMD, `wr_ready` outside ADDR/DATA, and `finish` outside WAIT_FSH.

## Timing
- Reset value of every output is 0, except `cmd` (4'd1), `rd_ready` (1) and `addr` (`DEV_ADDR`). Reset also forces IDLE and clears all counters.
- Reset is asynchronous: outputs drop immediately.
- Reset mid-transfer abandons the burst; the I2C master must be reset alongside.
- `start` to `cmd_vld` latency: 2 cycles (latch, then CMD register).
- `cmd_vld`, `busy`, `done` and the address-phase `wr_vld`/`wr_data` are registered outputs.
- DATA-phase `wr_vld`/`wr_data`/`src_ready` are combinational from inputs and state.
- No `wr_vld` drop while waiting for `wr_ready` in ADDR. In DATA, a `wr_vld` drop follows `src_vld` only.
- `finish` to the next burst's `cmd_vld`: TWR_CYCLES + 1 cycles.
- `len == 0`: `done` pulses 2 cycles after `start`; `cmd_vld` never rises.
- Back-to-back operation: `start` in the cycle after `done` is accepted.

## Test plan
Configuration unless noted: DEV_ADDR=7'h50, ADDR_BYTES=2, PAGE_BYTES=16, TWR_CYCLES=100.
- Aligned full page: start_addr 0x0000, len 16, src bytes 0x00..0x0F.
  - Required response: one burst with `burst_len` 18, address bytes 0x00,0x00, then data 0x00..0x0F.
  - `wr_last` on 0x0F; `done` 102 cycles after `finish`.
- Page crossing: start_addr 0x000E, len 5.
  - First burst: `burst_len` 4, address 0x000E, 2 bytes.
  - Wait 100 cycles.
  - Second burst: `burst_len` 5, address 0x0010, 3 bytes; stream order preserved.
- Zero length: len 0.
  - Required response: `done` at cycle +2, `cmd_vld` and `wr_vld` never high, `src_ready` stays 0.
- Backpressure: random `src_vld` gaps plus `wr_ready` low for 1-5 cycles, len 40 from 0x0005.
  - Required response: bursts of 11, 16 and 13 data bytes.
  - Scoreboard shows no byte lost or duplicated; `wr_data` stable while `wr_vld & ~wr_ready`.
- Single-byte address mode: ADDR_BYTES=1, start_addr 0x2F3, len 2.
  - Required response: `addr` 7'h52, single address byte 0xF3, `burst_len` 3.
- Reset mid-DATA: assert `rst` after 3 data bytes.
  - Required response: all outputs return to reset values in the same cycle, with no further `cmd_vld`.
  - A new `start` after reset completes normally.

Source files
------------

// File: rtl/iic_eeprom_wr_block.sv
// Page-aware EEPROM block writer: turns a ready/valid byte stream into page-aligned
// COMPLETE_WR bursts for an I2C master, waiting the EEPROM write cycle between bursts.
module iic_eeprom_wr_block #(
   parameter logic [6:0] DEV_ADDR   = 7'b1010_000,
   parameter int         ADDR_BYTES = 2,
   parameter int         PAGE_BYTES = 16,
   parameter int         MEM_AW     = 16,
   parameter int         LEN_W      = 16,
   parameter int         TWR_CYCLES = 500000
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic [MEM_AW-1:0] start_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   input  logic [7:0]        src_data,
   input  logic              src_vld,
   output logic              src_ready,
   output logic [3:0]        cmd,
   output logic              cmd_vld,
   input  logic              cmd_ready,
   output logic [6:0]        addr,
   output logic [23:0]       burst_len,
   output logic [7:0]        wr_data,
   output logic              wr_vld,
   input  logic              wr_ready,
   output logic              wr_last,
   output logic              rd_ready,
   input  logic              finish
);

   localparam int PB_W = $clog2(PAGE_BYTES);
   localparam int N_W  = PB_W + 1;
   localparam int TW_W = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DATA, WAIT_FSH, TWR, DONE
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [MEM_AW-1:0] r_curAddr;
   logic [LEN_W-1:0]  r_remain;
   logic [N_W-1:0]    r_n;
   logic [PB_W-1:0]   r_cnt;
   logic              r_aIdx;
   logic [TW_W-1:0]   r_twrCnt;
   logic              r_cmdVld;
   logic              r_busy;
   logic              r_done;
   logic              r_wrVldA;
   logic [7:0]        r_wrDataA;
   logic [6:0]        r_addr;
   logic [23:0]       r_burstLen;

   logic [15:0]       w_addrWide;
   logic [PB_W-1:0]   w_pageOff;
   logic [N_W-1:0]    w_space;
   logic [N_W-1:0]    w_chunk;
   logic [N_W-1:0]    w_lastIdx;
   logic [6:0]        w_devAddr;
   logic [23:0]       w_burstLen;
   logic              w_cmdAcc;
   logic              w_addrAcc;
   logic              w_dataAcc;
   logic              w_dataLast;
   logic              w_twrEnd;
   logic              w_loadBurst;

   assign w_addrWide  = 16'(r_curAddr);
   assign w_pageOff   = r_curAddr[PB_W-1:0];
   assign w_space     = N_W'(PAGE_BYTES) - {1'b0, w_pageOff};
   assign w_chunk     = (32'(r_remain) < 32'(w_space)) ? N_W'(r_remain) : w_space;
   assign w_lastIdx   = r_n - N_W'(1);
   assign w_devAddr   = (ADDR_BYTES == 1) ? (DEV_ADDR | {4'b0, w_addrWide[10:8]}) : DEV_ADDR;
   assign w_burstLen  = 24'(ADDR_BYTES) + 24'(w_chunk);
   assign w_cmdAcc    = (r_state == CMD) && r_cmdVld && cmd_ready;
   assign w_addrAcc   = (r_state == ADDR) && r_wrVldA && wr_ready;
   assign w_dataAcc   = (r_state == DATA) && src_vld && wr_ready;
   assign w_dataLast  = (N_W'(r_cnt) == w_lastIdx);
   assign w_twrEnd    = (r_state == TWR) && (r_twrCnt == TW_W'(TWR_CYCLES - 1));
   // A burst is sized either on the first CMD cycle after start (addresses just latched)
   // or straight out of TWR, where cur_addr/remain are already up to date.
   assign w_loadBurst = ((r_state == CMD) && !r_cmdVld) || (w_twrEnd && (r_remain != '0));

   always_ff @(posedge clock or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:     if (start) w_nextState = (len == '0) ? DONE : CMD;
         CMD:      if (w_cmdAcc) w_nextState = ADDR;
         ADDR:     if (w_addrAcc && r_aIdx) w_nextState = DATA;
         DATA:     if (w_dataAcc && w_dataLast) w_nextState = WAIT_FSH;
         WAIT_FSH: if (finish) w_nextState = TWR;
         TWR:      if (w_twrEnd) w_nextState = (r_remain != '0) ? CMD : DONE;
         DONE:     w_nextState = IDLE;
         default:  w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_curAddr  <= '0;
         r_remain   <= '0;
         r_n        <= '0;
         r_cnt      <= '0;
         r_aIdx     <= 1'b0;
         r_twrCnt   <= '0;
         r_cmdVld   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wrVldA   <= 1'b0;
         r_wrDataA  <= '0;
         r_addr     <= DEV_ADDR;
         r_burstLen <= '0;
      end else begin
         r_busy   <= (w_nextState != IDLE);
         r_done   <= (r_state == DONE);
         r_twrCnt <= ((r_state == TWR) && !w_twrEnd) ? r_twrCnt + 1'b1 : '0;

         if ((r_state == IDLE) && start) begin
            r_curAddr <= start_addr;
            r_remain  <= len;
         end

         if (w_loadBurst) begin
            r_n        <= w_chunk;
            r_burstLen <= w_burstLen;
            r_addr     <= w_devAddr;
            r_cmdVld   <= 1'b1;
         end else if (w_cmdAcc) begin
            r_cmdVld  <= 1'b0;
            r_wrVldA  <= 1'b1;
            r_aIdx    <= (ADDR_BYTES == 1);
            r_wrDataA <= (ADDR_BYTES == 1) ? w_addrWide[7:0] : w_addrWide[15:8];
         end

         // r_aIdx marks that the low address byte is the one currently on the bus
         if (w_addrAcc) begin
            if (r_aIdx) begin
               r_wrVldA <= 1'b0;
            end else begin
               r_aIdx    <= 1'b1;
               r_wrDataA <= w_addrWide[7:0];
            end
         end

         if (w_dataAcc) begin
            if (w_dataLast) begin
               r_cnt     <= '0;
               r_curAddr <= r_curAddr + MEM_AW'(r_n);
               r_remain  <= r_remain - LEN_W'(r_n);
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign cmd       = 4'd1;
   assign cmd_vld   = r_cmdVld;
   assign addr      = r_addr;
   assign burst_len = r_burstLen;
   assign rd_ready  = 1'b1;
   assign wr_vld    = (r_state == DATA) ? src_vld  : r_wrVldA;
   assign wr_data   = (r_state == DATA) ? src_data : r_wrDataA;
   assign src_ready = (r_state == DATA) && wr_ready;
   assign wr_last   = (r_state == DATA) && w_dataLast;

endmodule
